pc_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 27 ++
 rtl/pc_next_mux.sv | 37 +++
 rtl/pc_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared types and default constants for the fetch sequencer.
//   state_t : fetch FSM states (BOOT, RUN, WAIT)
//   src_t   : source selector for the next PC value
//   DEF_*   : default width and vector constants used as parameter defaults
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_SEQ   = 2'd0,
        SRC_REDIR = 2'd1,
        SRC_EXC   = 2'd2
    } src_t;

    localparam int          DEF_WIDTH        = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
    localparam int          DEF_PC_STEP      = 4;

endpackage

// File: rtl/pc_next_mux.sv
// ----------------------------------------------------------------------------
// pc_next_mux
// Combinational select of the next PC from a source code.
//   src      in  : SRC_SEQ / SRC_REDIR / SRC_EXC
//   pc_q     in  : current PC
//   target   in  : raw redirect target (low two bits are cleared here)
//   pc_next  out : selected next PC
// Sequential increment wraps modulo 2^WIDTH.
// ----------------------------------------------------------------------------
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
    parameter int               PC_STEP    = DEF_PC_STEP
) (
    input  src_t             src,
    input  logic [WIDTH-1:0] pc_q,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_next
);

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(2'b11));

    // Select next PC; redirect targets are forced word-aligned.
    always_comb begin
        pc_next = pc_q + STEP_W;
        case (src)
            SRC_SEQ:   pc_next = pc_q + STEP_W;
            SRC_REDIR: pc_next = target & ALIGN_MASK;
            SRC_EXC:   pc_next = EXC_VECTOR;
            default:   pc_next = pc_q + STEP_W;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Fetch controller: drives the PC register (pc_en/pc_next), runs the
// instruction memory req/ack handshake and hands each fetched word, tagged
// with its PC, to decode.
//
// Ports
//   clk, reset                     : clock, synchronous active-high reset
//   stall                          : hold; no new fetch starts while high
//   redirect_valid/redirect_target : one-cycle branch/jump pulse + target
//   exc_req                        : one-cycle exception pulse
//   pc_q                           : current PC (PC register q)
//   pc_en, pc_next                 : PC register enable / d
//   imem_req, imem_addr            : fetch request / address
//   imem_ack, imem_rdata           : fetch complete / fetched word
//   inst_valid, inst, inst_pc      : registered instruction to decode
//
// Build option
//   DELAY_SLOT_EN : when defined, a captured redirect arms on the first ack
//                   (that fetch completes sequentially) and the target is
//                   loaded on the second ack.
// ----------------------------------------------------------------------------
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               PC_STEP      = DEF_PC_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_req,
    input  logic [WIDTH-1:0] pc_q,
    output logic             pc_en,
    output logic [WIDTH-1:0] pc_next,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc
);

    state_t           state_r;
    logic             exc_pend_r;
    logic             redir_pend_r;
    logic [WIDTH-1:0] redir_tgt_r;
    logic             inst_valid_r;
    logic [WIDTH-1:0] inst_r;
    logic [WIDTH-1:0] inst_pc_r;
`ifdef DELAY_SLOT_EN
    logic             armed_r;
    logic             armed_s;
`endif

    logic             exc_s;
    logic             redir_any_s;
    logic [WIDTH-1:0] tgt_s;
    logic             ack_s;
    logic             take_exc_s;
    src_t             ack_src_s;
    src_t             src_s;
    logic             boot_s;
    logic [WIDTH-1:0] mux_pc_s;
    logic             exc_pend_s;
    logic             redir_pend_s;
    logic [WIDTH-1:0] redir_tgt_s;

    // A same-cycle pulse counts as pending; a same-cycle redirect is newer.
    assign exc_s       = exc_pend_r | exc_req;
    assign redir_any_s = redir_pend_r | redirect_valid;
    assign tgt_s       = redirect_valid ? redirect_target : redir_tgt_r;
    assign ack_s       = (state_r == WAIT) && imem_ack;
    assign take_exc_s  = exc_s && ((state_r == RUN) || ack_s);

    // Priority of the PC source on an ack cycle.
    always_comb begin
        ack_src_s = SRC_SEQ;
        if (exc_s) begin
            ack_src_s = SRC_EXC;
`ifdef DELAY_SLOT_EN
        end else if (armed_r) begin
`else
        end else if (redir_any_s) begin
`endif
            ack_src_s = SRC_REDIR;
        end else begin
            ack_src_s = SRC_SEQ;
        end
    end

    // PC register and fetch handshake controls, decoded from the state.
    always_comb begin
        pc_en    = 1'b0;
        imem_req = 1'b0;
        src_s    = SRC_SEQ;
        boot_s   = 1'b0;
        if (reset) begin
            pc_en    = 1'b0;
            imem_req = 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    pc_en  = 1'b1;
                    boot_s = 1'b1;
                end
                RUN: begin
                    if (exc_s) begin
                        pc_en = 1'b1;
                        src_s = SRC_EXC;
                    end else begin
                        pc_en = 1'b0;
                    end
                end
                WAIT: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        pc_en = 1'b1;
                        src_s = ack_src_s;
                    end else begin
                        pc_en = 1'b0;
                    end
                end
                default: begin
                    pc_en    = 1'b0;
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    pc_next_mux #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR),
        .PC_STEP    (PC_STEP)
    ) u_pc_next_mux (
        .src     (src_s),
        .pc_q    (pc_q),
        .target  (tgt_s),
        .pc_next (mux_pc_s)
    );

    assign pc_next   = boot_s ? RESET_VECTOR : mux_pc_s;
    assign imem_addr = pc_q;

    // Next values of the pending exception / redirect bookkeeping.
    always_comb begin
        exc_pend_s   = exc_pend_r;
        redir_pend_s = redir_pend_r;
        redir_tgt_s  = redir_tgt_r;
`ifdef DELAY_SLOT_EN
        armed_s      = armed_r;
`endif
        if (take_exc_s) begin
            // Taking an exception flushes everything, including a
            // redirect arriving in the same cycle.
            exc_pend_s   = 1'b0;
            redir_pend_s = 1'b0;
`ifdef DELAY_SLOT_EN
            armed_s      = 1'b0;
`endif
        end else if (ack_s) begin
            redir_pend_s = 1'b0;
`ifdef DELAY_SLOT_EN
            if (armed_r) begin
                armed_s = 1'b0;
            end else if (redir_any_s) begin
                armed_s     = 1'b1;
                redir_tgt_s = tgt_s;
            end else begin
                armed_s = 1'b0;
            end
`endif
        end else if (exc_req) begin
            exc_pend_s   = 1'b1;
            redir_pend_s = 1'b0;
`ifdef DELAY_SLOT_EN
            armed_s      = 1'b0;
`endif
        end else if (redirect_valid && !exc_pend_r) begin
            redir_tgt_s = redirect_target;
`ifdef DELAY_SLOT_EN
            // Once armed, a newer redirect only replaces the target.
            redir_pend_s = ~armed_r;
`else
            redir_pend_s = 1'b1;
`endif
        end else begin
            exc_pend_s = exc_pend_r;
        end
    end

    // Fetch FSM, pending flags and registered instruction outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= BOOT;
            exc_pend_r   <= 1'b0;
            redir_pend_r <= 1'b0;
            redir_tgt_r  <= '0;
`ifdef DELAY_SLOT_EN
            armed_r      <= 1'b0;
`endif
            inst_valid_r <= 1'b0;
            inst_r       <= '0;
            inst_pc_r    <= '0;
        end else begin
            exc_pend_r   <= exc_pend_s;
            redir_pend_r <= redir_pend_s;
            redir_tgt_r  <= redir_tgt_s;
`ifdef DELAY_SLOT_EN
            armed_r      <= armed_s;
`endif
            inst_valid_r <= 1'b0;
            case (state_r)
                BOOT: state_r <= RUN;
                RUN: begin
                    if (!take_exc_s && !stall) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state_r <= RUN;
                        // A word fetched alongside an exception is dropped.
                        if (!exc_s) begin
                            inst_valid_r <= 1'b1;
                            inst_r       <= imem_rdata;
                            inst_pc_r    <= pc_q;
                        end
                    end
                end
                default: state_r <= BOOT;
            endcase
        end
    end

    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: a directed vector table followed by
// randomized traffic checked against a transaction-level reference model.
// The bench owns the PC register (pc_q) and a simple instruction memory.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam logic [31:0] RST_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        exc_req = 1'b0;
    logic [31:0] pc_q = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_req         (exc_req),
        .pc_q            (pc_q),
        .pc_en           (pc_en),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    // PC register owned by the bench.
    always @(posedge clk) begin
        if (pc_en === 1'b1) pc_q <= pc_next;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [31:0] sel(input logic [31:0] a, input logic [31:0] b);
        return DS ? b : a;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending redirect is tracked as "acks remaining before the target
    // loads": 1 normally, 2 with a delay slot.
    bit          m_boot  = 1'b1;
    bit          m_fetch = 1'b0;
    bit          m_exc   = 1'b0;
    int          m_rcnt  = 0;
    logic [31:0] m_tgt   = 32'h0;
    logic [31:0] m_pc    = 32'h0;
    bit          e_valid = 1'b0;
    logic [31:0] e_inst  = 32'h0;
    logic [31:0] e_ipc   = 32'h0;

    task automatic note_events(input bit rv, input bit exc, input logic [31:0] tgt);
        if (exc) begin
            m_exc  = 1'b1;
            m_rcnt = 0;
        end else if (rv && !m_exc) begin
            m_tgt = tgt;
            if (m_rcnt == 0) m_rcnt = DS ? 2 : 1;
        end
    endtask

    task automatic model_step(input bit rst, input bit stl, input bit rv, input bit exc,
                              input bit ack, input logic [31:0] tgt,
                              output bit ld, output logic [31:0] npc);
        ld  = 1'b0;
        npc = m_pc;
        if (rst) begin
            m_boot = 1'b1; m_fetch = 1'b0; m_exc = 1'b0; m_rcnt = 0; m_tgt = 32'h0;
            e_valid = 1'b0; e_inst = 32'h0; e_ipc = 32'h0;
        end else begin
            e_valid = 1'b0;
            if (m_boot) begin
                ld = 1'b1; npc = RST_VEC; m_boot = 1'b0;
                note_events(rv, exc, tgt);
            end else if (!m_fetch) begin
                if (m_exc || exc) begin
                    ld = 1'b1; npc = EXC_VEC; m_exc = 1'b0; m_rcnt = 0;
                end else begin
                    note_events(rv, 1'b0, tgt);
                    m_fetch = !stl;
                end
            end else if (ack) begin
                ld = 1'b1; m_fetch = 1'b0;
                if (m_exc || exc) begin
                    npc = EXC_VEC; m_exc = 1'b0; m_rcnt = 0;
                end else begin
                    if (rv) begin
                        m_tgt = tgt;
                        if (m_rcnt == 0) m_rcnt = DS ? 2 : 1;
                    end
                    e_valid = 1'b1; e_inst = mem_word(m_pc); e_ipc = m_pc;
                    if (m_rcnt == 1) begin
                        npc = {m_tgt[31:2], 2'b00};
                        m_rcnt = 0;
                    end else begin
                        npc = m_pc + 32'd4;
                        if (m_rcnt > 1) m_rcnt = m_rcnt - 1;
                    end
                end
            end else begin
                note_events(rv, exc, tgt);
            end
            if (ld) m_pc = npc;
        end
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, then
    // check registered outputs just after the edge.
    task automatic run_cycle(input bit rst, input bit stl, input bit rv, input bit exc,
                             input bit ack, input logic [31:0] tgt,
                             output bit o_en, output logic [31:0] o_next, output bit o_req,
                             output bit o_vld, output logic [31:0] o_ipc);
        bit          ld;
        bit          ereq;
        logic [31:0] npc;
        logic [31:0] addr_exp;
        reset = rst; stall = stl; redirect_valid = rv; redirect_target = tgt;
        exc_req = exc; imem_ack = ack;
        imem_rdata = mem_word(pc_q);
        #3;
        ereq     = !rst && m_fetch;
        addr_exp = m_pc;
        model_step(rst, stl, rv, exc, ack, tgt, ld, npc);
        o_en = pc_en; o_next = pc_next; o_req = imem_req;
        check("pc_en", {31'd0, pc_en}, {31'd0, ld});
        if (ld) check("pc_next", pc_next, npc);
        check("imem_req", {31'd0, imem_req}, {31'd0, ereq});
        if (ereq) check("imem_addr", imem_addr, addr_exp);
        @(posedge clk);
        #1;
        o_vld = inst_valid; o_ipc = inst_pc;
        check("inst_valid", {31'd0, inst_valid}, {31'd0, e_valid});
        check("inst", inst, e_inst);
        check("inst_pc", inst_pc, e_ipc);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rst, stl, rv, exc, ack;
        logic [31:0] tgt;
        bit          en;
        logic [31:0] nxt;
        bit          req;
        bit          vld;
        logic [31:0] ipc;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit stl, input bit rv, input bit exc,
                                input bit ack, input logic [31:0] tgt, input bit en,
                                input logic [31:0] nxt, input bit req, input bit vld,
                                input logic [31:0] ipc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rv = rv; v.exc = exc; v.ack = ack; v.tgt = tgt;
        v.en = en; v.nxt = nxt; v.req = req; v.vld = vld; v.ipc = ipc;
        return v;
    endfunction

    vec_t tbl[32];

    initial begin
        bit          o_en, o_req, o_vld;
        logic [31:0] o_next, o_ipc, p9, p25, p27;
        p9  = sel(32'h100, 32'hC);
        p25 = sel(32'hFFFF_FFFC, 32'h88);
        p27 = sel(32'h0, 32'hFFFF_FFFC);
        //            rst  stl  rv   exc  ack  tgt            en   nxt                              req  vld  ipc
        tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,32'h0);
        tbl[1]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h0,                           1'b0,1'b0,32'h0);
        tbl[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b0,32'h0,                           1'b0,1'b0,32'h0);
        tbl[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h4,                           1'b1,1'b1,32'h0);
        tbl[4]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b0,32'h0,                           1'b0,1'b0,32'h0);
        tbl[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h8,                           1'b1,1'b1,32'h4);
        tbl[6]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b0,32'h0,                           1'b0,1'b0,32'h4);
        tbl[7]  = mk(1'b0,1'b0,1'b1,1'b0,1'b1,32'h103,       1'b1,sel(32'h100, 32'hC),             1'b1,1'b1,32'h8);
        tbl[8]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b0,32'h0,                           1'b0,1'b0,32'h8);
        tbl[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,sel(32'h104, 32'h100),           1'b1,1'b1,p9);
        tbl[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,p9);
        tbl[11] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,32'h200,       1'b0,32'h0,                           1'b1,1'b0,p9);
        tbl[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h80,                          1'b1,1'b0,p9);
        tbl[13] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,p9);
        tbl[14] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,p9);
        tbl[15] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,p9);
        tbl[16] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,p9);
        tbl[17] = mk(1'b0,1'b1,1'b0,1'b1,1'b0,32'h0,         1'b1,32'h80,                          1'b0,1'b0,p9);
        tbl[18] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,p9);
        tbl[19] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b1,1'b0,p9);
        tbl[20] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b1,1'b0,p9);
        tbl[21] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h84,                          1'b1,1'b1,32'h80);
        tbl[22] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'hFFFF_FFFF, 1'b0,32'h0,                           1'b0,1'b0,32'h80);
        tbl[23] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,sel(32'hFFFF_FFFC, 32'h88),      1'b1,1'b1,32'h84);
        tbl[24] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,32'h84);
        tbl[25] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,sel(32'h0, 32'hFFFF_FFFC),       1'b1,1'b1,p25);
        tbl[26] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,p25);
        tbl[27] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,sel(32'h4, 32'h0),               1'b1,1'b1,p27);
        tbl[28] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,p27);
        tbl[29] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b1,1'b0,p27);
        tbl[30] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,                           1'b0,1'b0,32'h0);
        tbl[31] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0,                           1'b0,1'b0,32'h0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            run_cycle(tbl[i].rst, tbl[i].stl, tbl[i].rv, tbl[i].exc, tbl[i].ack, tbl[i].tgt,
                      o_en, o_next, o_req, o_vld, o_ipc);
            check($sformatf("tbl[%0d].pc_en", i), {31'd0, o_en}, {31'd0, tbl[i].en});
            if (tbl[i].en) check($sformatf("tbl[%0d].pc_next", i), o_next, tbl[i].nxt);
            check($sformatf("tbl[%0d].imem_req", i), {31'd0, o_req}, {31'd0, tbl[i].req});
            check($sformatf("tbl[%0d].inst_valid", i), {31'd0, o_vld}, {31'd0, tbl[i].vld});
            check($sformatf("tbl[%0d].inst_pc", i), o_ipc, tbl[i].ipc);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit          r_rst, r_stl, r_rv, r_exc, r_ack;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(127) == 0);
            r_stl = ($urandom_range(3) == 0);
            r_rv  = ($urandom_range(7) == 0);
            r_exc = ($urandom_range(15) == 0);
            r_ack = m_fetch && ($urandom_range(2) == 0);
            r_tgt = $urandom();
            run_cycle(r_rst, r_stl, r_rv, r_exc, r_ack, r_tgt, o_en, o_next, o_req, o_vld, o_ipc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
